// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a DEPTH-entry {pc, inst} queue.
// Issues one word fetch per cycle while the queue plus the outstanding request
// leave room, accepts the 1-cycle-latency response and presents queued
// instructions to decode through a valid/ready handshake.
// Optional build macro FETCH_UNIT_STATS_EN adds stat_fetched / stat_flushes.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_UNIT_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [15:0]       stat_flushes
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              fly;
  logic [ADDR_W-1:0] fly_pc;
  entry_t            q [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, count;
  logic [PW+1:0]     occ;
  logic              empty, pop, push;

  // Extra pointer bit makes count == DEPTH distinguishable from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);

  // Outputs are forced to their reset values while reset is held low so the
  // interface is quiet even before the synchronous reset has been sampled.
  assign out_valid = reset && !empty;
  assign pop       = out_valid && out_ready;
  assign push      = reset && fly && !redir_valid;
  assign imem_addr = reset ? (pc & ALIGN) : RESET_PC;
  assign out_pc    = q[rd_ptr[PW-1:0]].pc;
  assign out_inst  = q[rd_ptr[PW-1:0]].inst;

  // Space still committed next cycle: queued + outstanding, minus this pop.
  assign occ = {1'b0, count} + {{(PW+1){1'b0}}, fly} - {{(PW+1){1'b0}}, pop};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state logic; a redirect always lands in FETCH or HALTED
  always_comb begin
    state_nxt = state;
    if (redir_valid) begin
      state_nxt = halt ? HALTED : FETCH;
    end else begin
      case (state)
        BOOT:    state_nxt = FETCH;
        FETCH:   if (halt)  state_nxt = HALTED;
        HALTED:  if (!halt) state_nxt = FETCH;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // Fetch request: only in FETCH, never alongside a redirect (PC is replaced)
  always_comb begin
    imem_req = 1'b0;
    if (reset && state == FETCH && !halt && !redir_valid &&
        occ < (PW+2)'(DEPTH))
      imem_req = 1'b1;
  end

  // PC and the single outstanding request; redirect drops the in-flight one
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc  <= RESET_PC;
      fly <= 1'b0;
    end else if (redir_valid) begin
      pc  <= redir_pc & ALIGN;
      fly <= 1'b0;
    end else begin
      fly <= imem_req;
      if (imem_req) begin
        fly_pc <= pc;
        pc     <= pc + ADDR_W'(4);
      end
    end
  end

  // Queue pointers; a redirect flushes by collapsing both pointers
  always_ff @(posedge clock) begin
    if (!reset || redir_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Queue storage; the response is tagged with the PC of its request
  always_ff @(posedge clock) begin
    if (push) q[wr_ptr[PW-1:0]] <= '{pc: fly_pc, inst: imem_data};
  end

`ifdef FETCH_UNIT_STATS_EN
  // Saturating counters of pushed instructions and redirects
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (push && stat_fetched != '1)        stat_fetched <= stat_fetched + 32'd1;
      if (redir_valid && stat_flushes != '1) stat_flushes <= stat_flushes + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random stimulus against a queue-based reference
// model of the fetch unit; every cycle the outputs are compared at negedge.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam logic [31:0] K     = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset, redir_valid, halt, out_ready;
  logic [31:0] redir_pc, imem_data;
  logic [31:0] imem_addr, out_inst, out_pc;
  logic        imem_req, out_valid;
`ifdef FETCH_UNIT_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushes;
`endif

  fetch_unit dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_UNIT_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  // Reference model: queue of expected entries plus fetch bookkeeping
  ent_t        mq[$];
  logic [31:0] m_pc, m_fly_pc;
  bit          m_fly, m_boot, m_halt;
  int          m_fetched, m_flushes;

  int          n_assert = 0, n_fail = 0;
  logic [31:0] nxt_data, s_addr, s_out_pc, hp;
  logic        s_valid, s_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RPC; m_fly = 0; m_boot = 1; m_halt = 0;
    m_fetched = 0; m_flushes = 0;
  endtask

  // One clock: check at negedge, then advance the model at posedge.
  task automatic cycle();
    bit e_valid, e_req, e_pop;
    logic [31:0] e_addr;
    @(negedge clock);
    if (!reset) begin
      e_valid = 0; e_req = 0; e_pop = 0; e_addr = RPC;
    end else begin
      e_valid = mq.size() > 0;
      e_pop   = e_valid && out_ready;
      e_addr  = m_pc;
      e_req   = !m_boot && !m_halt && !halt && !redir_valid &&
                (mq.size() + int'(m_fly) - int'(e_pop) < DEPTH);
    end
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("imem_req",  32'(imem_req),  32'(e_req));
    chk("imem_addr", imem_addr, e_addr);
    if (e_valid) begin
      chk("out_pc",   out_pc,   mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
`ifdef FETCH_UNIT_STATS_EN
    chk("stat_fetched", stat_fetched, 32'(m_fetched));
    chk("stat_flushes", 32'(stat_flushes), 32'(m_flushes));
`endif
    s_valid = out_valid; s_req = imem_req; s_addr = imem_addr; s_out_pc = out_pc;
    nxt_data = imem_addr ^ K;
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else if (redir_valid) begin
      mq.delete();
      m_fly = 0;
      m_pc = redir_pc & ~32'h3;
      m_halt = halt;
      m_boot = 0;
      m_flushes++;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_fly) begin
        mq.push_back('{m_fly_pc, m_fly_pc ^ K});
        m_fetched++;
      end
      m_fly = e_req;
      if (e_req) begin
        m_fly_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
      m_halt = m_boot ? 1'b0 : halt;
      m_boot = 0;
    end
    #1 imem_data = nxt_data;
  endtask

  initial begin
    model_reset();
    reset = 0; out_ready = 1; halt = 0; redir_valid = 0; redir_pc = '0; imem_data = '0;
    repeat (3) cycle();

    // Stream from reset: head PCs on the 3rd..5th cycle after release
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i >= 3 && i <= 5) chk("boot_seq", s_out_pc, RPC + 32'(4 * (i - 3)));
    end

    // Backpressure: fill to DEPTH, then drain in order with no gap
    reset = 0; cycle(); reset = 1; out_ready = 0;
    repeat (10) cycle();
    chk("full_req", 32'(s_req), 32'd0);
    chk("full_valid", 32'(s_valid), 32'd1);
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("drain_valid", 32'(s_valid), 32'd1);
      chk("drain_pc", s_out_pc, RPC + 32'(4 * i));
    end

    // Redirect with 3 queued entries
    reset = 0; cycle(); reset = 1; out_ready = 0;
    for (int i = 0; i < 20 && mq.size() != 3; i++) cycle();
    chk("fill3_bound", 32'(mq.size()), 32'd3);
    redir_valid = 1; redir_pc = 32'h0040_0103; cycle();
    redir_valid = 0; cycle();
    chk("redir_flush", 32'(s_valid), 32'd0);
    chk("redir_addr", s_addr, 32'h0040_0100);
    out_ready = 1;
    for (int i = 0; i < 10 && !s_valid; i++) cycle();
    chk("redir_first", s_out_pc, 32'h0040_0100);

    // Redirect alongside a pop with a response in flight
    repeat (4) cycle();
    redir_valid = 1; redir_pc = 32'h0080_1000; cycle();
    redir_valid = 0; cycle();
    for (int i = 0; i < 10 && !s_valid; i++) cycle();
    chk("redir_pop_first", s_out_pc, 32'h0080_1000);

    // Halt for 5 cycles, then resume at the next sequential PC
    repeat (3) cycle();
    halt = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) hp = s_addr;
      chk("halt_req", 32'(s_req), 32'd0);
    end
    chk("halt_drained", 32'(s_valid), 32'd0);
    halt = 0;
    for (int i = 0; i < 10 && !s_req; i++) cycle();
    chk("resume_addr", s_addr, hp);

    // One-cycle reset mid-stream
    repeat (4) cycle();
    reset = 0; cycle(); reset = 1; cycle();
    chk("rst_valid", 32'(s_valid), 32'd0);
`ifdef FETCH_UNIT_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'd0);
    chk("rst_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
    for (int i = 0; i < 10 && !s_valid; i++) cycle();
    chk("rst_restart", s_out_pc, RPC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(99) != 0);
      redir_valid = ($urandom_range(99) < 5);
      redir_pc    = $urandom;
      halt        = ($urandom_range(99) < 10);
      out_ready   = ($urandom_range(99) < 70);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
